vga_reg_writer: RTL



---
 rtl/vga_reg_pkg.sv | 28 ++
 rtl/vga_reg_writer_if.sv | 21 ++
 rtl/lowest_set_bit.sv | 21 ++
 rtl/vga_reg_writer.sv | 114 +++++++++++
 4 files changed

// File: rtl/vga_reg_pkg.sv
// rtl/vga_reg_pkg.sv - shared constants and writer state type for the VGA register writer
package vga_reg_pkg;

    localparam int NUM_REGS = 12;
    localparam int ADDR_W   = 9;
    localparam int DATA_W   = 32;

    localparam int REG_DINO_X     = 0;
    localparam int REG_DINO_Y     = 1;
    localparam int REG_JUMP_X     = 2;
    localparam int REG_JUMP_Y     = 3;
    localparam int REG_DUCK_X     = 4;
    localparam int REG_DUCK_Y     = 5;
    localparam int REG_CACTUS_X   = 6;
    localparam int REG_CACTUS_Y   = 7;
    localparam int REG_GODZILLA_X = 8;
    localparam int REG_GODZILLA_Y = 9;
    localparam int REG_SCORE_X    = 10;
    localparam int REG_SCORE_Y    = 11;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        WRITE,
        DONE
    } writer_state_t;

endpackage

// File: rtl/vga_reg_writer_if.sv
// rtl/vga_reg_writer_if.sv - register write bus between the writer and the VGA display slave
interface vga_reg_writer_if #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32
);
    logic              av_chipselect;
    logic              av_write;
    logic [ADDR_W-1:0] av_address;
    logic [DATA_W-1:0] av_writedata;
    logic              av_waitrequest;

    modport master (
        output av_chipselect, av_write, av_address, av_writedata,
        input  av_waitrequest
    );

    modport slave (
        input  av_chipselect, av_write, av_address, av_writedata,
        output av_waitrequest
    );
endinterface

// File: rtl/lowest_set_bit.sv
// rtl/lowest_set_bit.sv - priority encoder returning the index of the lowest set bit
module lowest_set_bit #(
    parameter int WIDTH = 12,
    parameter int IDX_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] bits,
    output logic [IDX_W-1:0] index,
    output logic             found
);
    // Walk downwards so the last assignment, the lowest set bit, wins.
    always_comb begin
        index = '0;
        found = 1'b0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (bits[i]) begin
                index = IDX_W'(i);
                found = 1'b1;
            end
        end
    end
endmodule

// File: rtl/vga_reg_writer.sv
// rtl/vga_reg_writer.sv - shadows game register updates and flushes changed ones to the display during vsync
module vga_reg_writer #(
    parameter int NUM_REGS = vga_reg_pkg::NUM_REGS,
    parameter int ADDR_W   = vga_reg_pkg::ADDR_W,
    parameter int DATA_W   = vga_reg_pkg::DATA_W
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    upd_valid,
    input  logic [3:0]              upd_index,
    input  logic [7:0]              upd_data,
    output logic                    upd_err,
    input  logic                    vga_vs_n,
    vga_reg_writer_if.master        bus,
    output logic                    busy,
    output logic                    frame_done,
    output logic                    overrun
);
    import vga_reg_pkg::*;

    localparam int IDX_W = $clog2(NUM_REGS);
    localparam logic [4:0] NUM_REGS_W = 5'(NUM_REGS);

    logic [NUM_REGS-1:0][7:0] shadow;
    logic [NUM_REGS-1:0]      dirty;
    logic [NUM_REGS-1:0]      snap;
    writer_state_t            state, state_nx;
    logic                     vs_prev;
    logic                     start;
    logic                     upd_hit;
    logic [IDX_W-1:0]         pick;
    logic                     found;
    logic [IDX_W-1:0]         cur_idx;
    logic                     cs_q, wr_q;
    logic [ADDR_W-1:0]        addr_q;
    logic [DATA_W-1:0]        data_q;

    assign start      = vs_prev & ~vga_vs_n;
    assign upd_hit    = upd_valid && ({1'b0, upd_index} < NUM_REGS_W);
    assign busy       = (state != IDLE);
    assign frame_done = (state == DONE);

    assign bus.av_chipselect = cs_q;
    assign bus.av_write      = wr_q;
    assign bus.av_address    = addr_q;
    assign bus.av_writedata  = data_q;

    lowest_set_bit #(.WIDTH(NUM_REGS), .IDX_W(IDX_W)) u_pick (
        .bits  (snap),
        .index (pick),
        .found (found)
    );

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = SCAN;
            SCAN:    state_nx = found ? WRITE : DONE;
            WRITE:   if (!bus.av_waitrequest) state_nx = SCAN;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            vs_prev <= 1'b1;
            overrun <= 1'b0;
            upd_err <= 1'b0;
            snap    <= '0;
            cur_idx <= '0;
            cs_q    <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            state   <= state_nx;
            vs_prev <= vga_vs_n;
            upd_err <= upd_valid & ~upd_hit;
            if (start && state != IDLE) overrun <= 1'b1;
            case (state)
                IDLE: if (start) snap <= dirty;
                SCAN: if (found) begin
                    addr_q  <= ADDR_W'(pick);
                    data_q  <= DATA_W'(shadow[pick]);
                    cur_idx <= pick;
                    cs_q    <= 1'b1;
                    wr_q    <= 1'b1;
                end
                WRITE: if (!bus.av_waitrequest) begin
                    cs_q          <= 1'b0;
                    wr_q          <= 1'b0;
                    snap[cur_idx] <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // A same-edge update to the entry being latched keeps it dirty for next frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shadow <= '0;
            dirty  <= '0;
        end else begin
            if (state == SCAN && found) dirty[pick] <= 1'b0;
            if (upd_hit) begin
                shadow[upd_index] <= upd_data;
                dirty[upd_index]  <= 1'b1;
            end
        end
    end
endmodule
